// File: rtl/cmp_pkg.sv
// Shared definitions for the sort controller: comparator result codes and FSM state encoding.
package cmp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_sort_ctrl_comparator.sv
// N-bit unsigned magnitude comparator producing the one-hot code {gt, eq, lt}.
module N_bit_comparator
    import cmp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [2:0]   result
);

    always_comb begin
        if (x > y) begin
            result = CMP_GT;
        end else if (x == y) begin
            result = CMP_EQ;
        end else begin
            result = CMP_LT;
        end
    end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Load / bubble-sort / drain controller sharing a single comparator across all compare steps.
// Optional macro CMP_SORT_EARLY_EXIT_EN ends the sort after the first pass that makes no swap.
module cmp_sort_ctrl
    import cmp_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy,
    output logic         sort_done
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_P   = CW'(DEPTH - 2);

    state_t state, state_next;

    logic [N-1:0]  mem [DEPTH];
    logic [CW-1:0] wcnt, p, j, rcnt;
    logic [IW-1:0] wi, ji, jn, ri;
    logic [2:0]    cmp_res;
    logic          swap_now;
    logic          pass_end;
    logic          sort_last;

    assign wi = wcnt[IW-1:0];
    assign ji = j[IW-1:0];
    assign jn = ji + 1'b1;
    assign ri = rcnt[IW-1:0];

    N_bit_comparator #(.N(N)) u_cmp (
        .x      (mem[ji]),
        .y      (mem[jn]),
        .result (cmp_res)
    );

    // Only a strict greater-than swaps, so equal words keep their order and 111 is ignored.
    assign swap_now = (state == SORT) && (cmp_res == CMP_GT);
    assign pass_end = (j == LAST_P - p);

`ifdef CMP_SORT_EARLY_EXIT_EN
    logic swapped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swapped <= 1'b0;
        end else if (state != SORT || pass_end) begin
            swapped <= 1'b0;
        end else if (swap_now) begin
            swapped <= 1'b1;
        end
    end

    assign sort_last = (state == SORT) && pass_end && ((p == LAST_P) || !(swapped || swap_now));
`else
    assign sort_last = (state == SORT) && pass_end && (p == LAST_P);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (in_valid && wcnt == LAST_IDX) state_next = SORT;
            SORT:    if (sort_last) state_next = DRAIN;
            DRAIN:   if (out_ready && rcnt == LAST_IDX) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Handshake outputs depend on state and storage only, never on in_valid or out_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        sort_done = 1'b0;
        case (state)
            LOAD:  in_ready = 1'b1;
            SORT: begin
                busy      = 1'b1;
                sort_done = sort_last;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = mem[ri];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wcnt <= '0;
            p    <= '0;
            j    <= '0;
            rcnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    p    <= '0;
                    j    <= '0;
                    rcnt <= '0;
                    if (in_valid) begin
                        mem[wi] <= in_data;
                        wcnt    <= (wcnt == LAST_IDX) ? '0 : wcnt + 1'b1;
                    end
                end
                SORT: begin
                    if (swap_now) begin
                        mem[ji] <= mem[jn];
                        mem[jn] <= mem[ji];
                    end
                    if (sort_last) begin
                        j <= '0;
                        p <= '0;
                    end else if (pass_end) begin
                        j <= '0;
                        p <= p + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        rcnt <= (rcnt == LAST_IDX) ? '0 : rcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl: table of batches plus scoreboard queue of expected output words.
module tb_cmp_sort_ctrl;

    localparam int N     = 4;
    localparam int DEPTH = 4;
`ifdef CMP_SORT_EARLY_EXIT_EN
    localparam int SORTED_BUSY = 3;
`else
    localparam int SORTED_BUSY = 6;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         busy;
    logic         sort_done;

    always #5 clk = ~clk;

    cmp_sort_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sort_done (sort_done)
    );

    typedef struct {
        logic [15:0] words;
        logic [15:0] sorted;
        int          busy_cycles;
        logic [7:0]  rpat;
        int          rlen;
        logic        hold7;
    } vec_t;

    vec_t       vecs [5];
    logic [3:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [15:0] pack4(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // Present the four words back to back; the last one is captured at the next rising edge.
    task automatic applyStimulus(input logic [15:0] words, input logic [15:0] sorted, input bit push);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checkOutput("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = words[4*i +: 4];
            if (push) exp_q.push_back(sorted[4*i +: 4]);
        end
    endtask

    task automatic waitSort(input int exp_busy, input logic hold7);
        int   busy_cnt = 0;
        int   done_cnt = 0;
        int   cyc = 0;
        logic done_last = 1'b0;
        logic ready_seen = 1'b0;
        @(negedge clk);
        in_valid = hold7;
        in_data  = hold7 ? 4'd7 : 4'd0;
        while (!out_valid && cyc < 40) begin
            if (busy) begin
                busy_cnt++;
                done_last = sort_done;
                if (in_ready) ready_seen = 1'b1;
            end
            if (sort_done) done_cnt++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("sort_reaches_drain", out_valid, 1);
        checkOutput("busy_cycles", busy_cnt, exp_busy);
        checkOutput("sort_done_pulses", done_cnt, 1);
        checkOutput("sort_done_on_last", done_last, 1);
        checkOutput("in_ready_in_sort", ready_seen, 0);
    endtask

    task automatic drainBatch(input logic [7:0] rpat, input int rlen);
        int         beats = 0;
        int         cyc = 0;
        logic       stalled = 1'b0;
        logic [3:0] held = '0;
        logic [3:0] e;
        while (beats < DEPTH && cyc < 40) begin
            out_ready = (cyc < rlen) ? rpat[cyc] : 1'b1;
            checkOutput("out_valid_drain", out_valid, 1);
            checkOutput("in_ready_drain", in_ready, 0);
            if (stalled) checkOutput("out_data_stall", out_data, held);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_underflow: actual beat %0d required none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", out_data, e);
                end
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checkOutput("drain_beats", beats, DEPTH);
        checkOutput("out_valid_after_drain", out_valid, 0);
        checkOutput("in_ready_after_drain", in_ready, 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_sort_done"}, sort_done, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nb;
        vecs[0] = '{pack4(4'd9, 4'd3, 4'd12, 4'd3), pack4(4'd3, 4'd3, 4'd9, 4'd12), 6, 8'h00, 0, 1'b0};
        vecs[1] = '{pack4(4'd15, 4'd10, 4'd5, 4'd0), pack4(4'd0, 4'd5, 4'd10, 4'd15), 6, 8'h00, 0, 1'b1};
        vecs[2] = '{pack4(4'd1, 4'd2, 4'd3, 4'd4), pack4(4'd1, 4'd2, 4'd3, 4'd4), SORTED_BUSY, 8'h00, 0, 1'b0};
        vecs[3] = '{pack4(4'd8, 4'd2, 4'd6, 4'd4), pack4(4'd2, 4'd4, 4'd6, 4'd8), 6, 8'b0101_1001, 7, 1'b0};
        vecs[4] = '{pack4(4'd5, 4'd1, 4'd5, 4'd0), pack4(4'd0, 4'd1, 4'd5, 4'd5), 6, 8'h00, 0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].words, vecs[i].sorted, 1'b1);
            waitSort(vecs[i].busy_cycles, vecs[i].hold7);
            drainBatch(vecs[i].rpat, vecs[i].rlen);
        end

        // Abort a batch on its third sort cycle; nothing from it may appear at the output.
        applyStimulus(pack4(4'd8, 4'd2, 4'd6, 4'd4), 16'h0000, 1'b0);
        nb = 0;
        for (int c = 0; c < 20 && nb < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (busy) nb++;
        end
        checkOutput("reach_sort_cycle3", nb, 3);
        rst_n = 1'b0;
        #1;
        checkResetState("midsort_reset");
        @(negedge clk);
        checkResetState("midsort_reset_held");
        rst_n = 1'b1;

        applyStimulus(vecs[4].words, vecs[4].sorted, 1'b1);
        waitSort(vecs[4].busy_cycles, vecs[4].hold7);
        drainBatch(vecs[4].rpat, vecs[4].rlen);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
- Sequencing controller that owns one shared N-bit magnitude comparator.
- Loads DEPTH words, sorts them ascending by bubble sort with one comparison per clock, then streams them out.
- Sits between a producer and a consumer; both use valid/ready handshakes.
- Comparator result is the team's one-hot 3-bit code: 100 = x>y, 010 = x==y, 001 = x<y.

Parameters:
- N, 4, data word width in bits (N >= 1).
- DEPTH, 4, number of words per sort batch (DEPTH >= 2).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller accepts a word this cycle.
- in_data  input  N  unsigned input word.
- out_valid  output  1  out_data holds a sorted word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  N  sorted word, smallest first.
- busy  output  1  high in SORT state.
- sort_done  output  1  one-cycle pulse on the cycle SORT exits to DRAIN.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=LOAD, all counters 0, in_ready=1, out_valid=0, out_data=0, busy=0, sort_done=0. Array contents are don't-care but are zeroed for determinism.
- Reset asserted mid-operation aborts immediately. The partial batch is discarded and no output beat is produced.
- Storage: reg array mem[0..DEPTH-1] of N bits. Word count wcnt, pass counter p, index j; each is $clog2(DEPTH+1) bits wide.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: mem[wcnt]<=in_data and wcnt++.
  - On the DEPTH-th accept: go to SORT with p=0, j=0.
- SORT:
  - in_ready=0, busy=1. in_valid is ignored; no word is lost because none is accepted.
  - Each cycle the comparator sees x=mem[j], y=mem[j+1] (combinational).
  - If comp==100, swap mem[j] and mem[j+1] at the clock edge. For 010 or 001, no swap, so equal words keep their order.
  - Advance j. When j==DEPTH-2-p, set j=0 and p++.
  - Exit when p reaches DEPTH-1.
  - With the pass-limited inner loop, latency is DEPTH*(DEPTH-1)/2 cycles, which is 6 for DEPTH=4.
  - sort_done pulses on the final SORT cycle; the next cycle is DRAIN.
- DRAIN:
  - out_valid=1 and out_data=mem[rcnt], with rcnt starting at 0.
  - On out_valid&&out_ready: rcnt++.
  - When out_ready is low, out_data and out_valid hold stable.
  - After the DEPTH-th beat: return to LOAD with counters cleared. in_ready is 1 on the next cycle, not the same cycle, so there is no overlap between the last output beat and a new load.
- Comparator value 111 (illegal): treated as no-swap.
- Only one comparator instance exists. No combinational path from in_valid to out_* or from out_ready to in_ready.

Optional Feature:
- Macro: CMP_SORT_EARLY_EXIT_EN.
- Defined: a swapped flag is cleared at the start of each pass and set on any swap. If a pass finishes with swapped==0, exit SORT immediately, with sort_done pulsing on that cycle. An already-sorted batch then takes DEPTH-1 cycles.
- Undefined: fixed latency DEPTH*(DEPTH-1)/2 cycles regardless of data; there is no swapped flag.

Decomposition:
- Shared package (cmp_pkg):
  - Result code constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
  - State encoding LOAD=2'd0, SORT=2'd1, DRAIN=2'd2.
- One sub-module: the existing N_bit_comparator, instantiated once with parameter N and driven from mem[j]/mem[j+1].
- FSM, counters and array stay in cmp_sort_ctrl.

Test Plan:
- N=4, DEPTH=4:
  - Load 9,3,12,3 back-to-back, out_ready=1 → busy for 6 cycles, one sort_done pulse, then out 3,3,9,12 on 4 consecutive cycles.
  - Load 15,10,5,0 → out 0,5,10,15. With CMP_SORT_EARLY_EXIT_EN defined, busy is still 6 cycles (worst case).
  - Load 1,2,3,4 → out 1,2,3,4. Busy is 6 cycles without the macro and 3 cycles with it.
- Hold in_valid=1 during SORT with in_data=7 → in_ready=0, and the next batch does not contain a stray 7.
- Drain 8,2,6,4 with out_ready toggling 1,0,0,1,1,0,1 → beats 2,4,6,8 in order; out_data is stable while stalled.
- Assert rst_n=0 for 1 cycle at SORT cycle 3 → all outputs at reset values, in_ready=1. The next batch 5,1,5,0 sorts to 0,1,5,5.
